// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART <-> ALU sequencer and its neighbours.
//   - state_t   : 3-bit state encoding of the command sequencer
//   - *_DEF     : default byte and opcode widths
//   - OP_*      : ALU opcode constants (ALU and bench use the same values)
package uart_alu_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'h20;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'h22;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'h24;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'h25;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'h26;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'h27;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'h03;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'h02;

endpackage

// File: rtl/uart_alu_ctrl_timeout.sv
// tick_timeout_counter: counts enabled baud ticks and flags the tick that
// brings the count to TIMEOUT_TICKS.
//   clk, i_rst   clock, async active-high reset
//   i_clear      clears the count; takes priority and suppresses expiry
//   i_en         counting allowed
//   i_tick       baud tick
//   o_expired    one-cycle pulse on the terminal tick (count then clears)
module tick_timeout_counter #(
    parameter int TIMEOUT_TICKS = 2048
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    input  logic i_tick,
    output logic o_expired
);

    localparam int NB_CNT = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [NB_CNT-1:0] LAST = NB_CNT'(TIMEOUT_TICKS - 1);

    logic [NB_CNT-1:0] count;
    logic              step;

    // A clear in the same cycle as the terminal tick wins, so an accepted
    // byte always beats the timeout.
    assign step      = i_en & i_tick & ~i_clear;
    assign o_expired = step & (count == LAST);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
        end else if (i_clear || o_expired) begin
            count <= '0;
        end else if (step) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: collects operand A, operand B and opcode bytes from the UART
// receiver, presents them to the ALU, hands the result byte to the UART
// transmitter and waits for it to finish. Partial commands are abandoned
// after TIMEOUT_TICKS baud ticks of silence.
//   clk, i_rst        clock, async active-high reset
//   i_baud_tick       baud tick shared with the UART
//   i_rx_data/done    received byte and its one-cycle strobe
//   i_alu_result      combinational ALU output
//   i_tx_done         transmitter finished
//   o_alu_a/b/op      registered ALU operands and opcode
//   o_tx_data/start   result byte and its one-cycle start pulse
//   o_busy            high outside S_WAIT_A
//   o_timeout         partial command discarded (pulse)
//   o_overrun         byte dropped while not accepting (pulse)
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA       = NB_DATA_DEF,
    parameter int NB_OP         = NB_OP_DEF,
    parameter int TIMEOUT_TICKS = 2048
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_baud_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_overrun
);

    state_t state;
    state_t state_next;
    logic   receiving;
    logic   accept;
    logic   expired;

    assign receiving = (state == S_WAIT_A) || (state == S_WAIT_B) || (state == S_WAIT_OP);
    assign accept    = i_rx_done & receiving;

    tick_timeout_counter #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_clear   (accept | ~(state == S_WAIT_B || state == S_WAIT_OP)),
        .i_en      ((state == S_WAIT_B) || (state == S_WAIT_OP)),
        .i_tick    (i_baud_tick),
        .o_expired (expired)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_WAIT_A:  if (i_rx_done) state_next = S_WAIT_B;
            S_WAIT_B:  if (i_rx_done) state_next = S_WAIT_OP;
                       else if (expired) state_next = S_WAIT_A;
            S_WAIT_OP: if (i_rx_done) state_next = S_EXEC;
                       else if (expired) state_next = S_WAIT_A;
            S_EXEC:    state_next = S_SEND;
            S_SEND:    state_next = S_WAIT_TX;
            S_WAIT_TX: if (i_tx_done) state_next = S_WAIT_A;
            default:   state_next = S_WAIT_A;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe without a combinational output path.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_WAIT_A;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            state      <= state_next;
            o_tx_start <= (state_next == S_SEND);
            o_busy     <= (state_next != S_WAIT_A);
            o_timeout  <= expired;
            o_overrun  <= i_rx_done & ~receiving;
            if (accept && state == S_WAIT_A) o_alu_a <= i_rx_data;
            if (accept && state == S_WAIT_B) o_alu_b <= i_rx_data;
            if (accept && state == S_WAIT_OP) o_alu_op <= i_rx_data[NB_OP-1:0];
            if (state == S_EXEC) o_tx_data <= i_alu_result;
        end
    end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Sequencer between the UART receiver/transmitter pair and the ALU. Collects three consecutive received bytes (operand A, operand B, opcode), presents them to the ALU, captures the result and hands it to the UART transmitter as a single byte, then waits for transmission to finish. It sits between `uart_rx`, the ALU and `uart_tx` in the top level. An inactivity timeout, counted in baud ticks, abandons partially received commands.

## Interface

Parameters:
- `NB_DATA`, 8, width of UART bytes, ALU operands and ALU result.
- `NB_OP`, 6, ALU opcode width; taken from bits `[NB_OP-1:0]` of the third byte (`NB_OP <= NB_DATA`).
- `TIMEOUT_TICKS`, 2048, `i_baud_tick` pulses allowed between bytes of one command; must be >= 2.

Ports:
- `clk`  in  1  system clock.
- `i_rst`  in  1  reset: asynchronous, active-high.
- `i_baud_tick`  in  1  one-cycle baud tick, shared with the UART.
- `i_rx_data`  in  NB_DATA  received byte; valid only while `i_rx_done`=1.
- `i_rx_done`  in  1  one-cycle pulse: byte received.
- `i_alu_result`  in  NB_DATA  combinational ALU output.
- `i_tx_done`  in  1  one-cycle pulse: transmitter finished its byte.
- `o_alu_a`  out  NB_DATA  registered operand A.
- `o_alu_b`  out  NB_DATA  registered operand B.
- `o_alu_op`  out  NB_OP  registered opcode.
- `o_tx_data`  out  NB_DATA  registered result byte for the transmitter.
- `o_tx_start`  out  1  one-cycle pulse: start transmission of `o_tx_data`.
- `o_busy`  out  1  high in every state except `S_WAIT_A`.
- `o_timeout`  out  1  one-cycle pulse: partial command discarded.
- `o_overrun`  out  1  one-cycle pulse: byte received while not accepting.

## Operation

- Reset: state `S_WAIT_A`. All outputs and the timeout counter are 0.
- States and transitions:
  - `S_WAIT_A`: on `i_rx_done`, latch `o_alu_a` and go to `S_WAIT_B`.
  - `S_WAIT_B`: on `i_rx_done`, latch `o_alu_b` and go to `S_WAIT_OP`.
  - `S_WAIT_OP`: on `i_rx_done`, latch `o_alu_op` and go to `S_EXEC`.
  - `S_EXEC`: 1 cycle; latch `i_alu_result` into `o_tx_data` and go to `S_SEND`.
  - `S_SEND`: 1 cycle; `o_tx_start`=1, then go to `S_WAIT_TX`.
  - `S_WAIT_TX`: on `i_tx_done`, go to `S_WAIT_A`.
- Operand and opcode registers hold their values until overwritten by the next command. They are not cleared on timeout.
- Timeout counter:
  - Cleared on every accepted byte and whenever the state is `S_WAIT_A`, `S_EXEC`, `S_SEND` or `S_WAIT_TX`.
  - Increments on `i_baud_tick` in `S_WAIT_B` and `S_WAIT_OP`.
  - When it reaches `TIMEOUT_TICKS`: next state is `S_WAIT_A`, `o_timeout` pulses, and the counter clears.
- Simultaneous `i_rx_done` and the terminal baud tick: the byte wins. It is accepted, the counter clears and no timeout occurs.
- `i_rx_done` in `S_EXEC`, `S_SEND` or `S_WAIT_TX`: the byte is dropped and `o_overrun` pulses. State is unaffected.
- `i_tx_done` outside `S_WAIT_TX`: ignored.
- `i_rst` asserted mid-command: immediate return to reset values. No `o_tx_start` is issued afterwards for the aborted command.

## Timing

- All outputs are registered. No combinational path from any input to any output.
- Opcode byte `i_rx_done` in cycle N:
  - `o_alu_op` valid and state `S_EXEC` from cycle N+1.
  - Result sampled at the end of N+1.
  - `o_tx_start`=1 and `o_tx_data` valid in cycle N+2.
  - State `S_WAIT_TX` from N+3.
- `o_tx_data` remains stable until the next `S_EXEC`.
- `i_tx_done` in cycle M: state `S_WAIT_A` and `o_busy`=0 from M+1. A byte arriving in M+1 is accepted.
- `o_timeout` and `o_overrun` are high for exactly one cycle per event.

## Structure

- Shared package `uart_alu_pkg`:
  - State encoding: 3-bit localparams `S_WAIT_A`…`S_WAIT_TX`.
  - Default `NB_DATA`/`NB_OP`.
  - ALU opcode constants, used by the ALU and the bench.
- Timeout counter is a natural sub-module, `tick_timeout_counter`:
  - Parameter `TIMEOUT_TICKS`.
  - Inputs `clk`, `i_rst`, `i_clear`, `i_en`, `i_tick`.
  - Output `o_expired`, a one-cycle pulse.
  - Counter width `$clog2(TIMEOUT_TICKS+1)`.

## Test plan

- Bytes 0x05, 0x03, opcode 0x20 (ALU ADD model returns 0x08), then `i_tx_done` 10 cycles after start -> single `o_tx_start` pulse exactly 2 cycles after the third `i_rx_done`, with `o_tx_data`=0x08; `o_busy` falls the cycle after `i_tx_done`.
- Bytes 0x05, 0x03, then silence with `TIMEOUT_TICKS`=4 -> `o_timeout` pulse after the 4th baud tick; state `S_WAIT_A`; next bytes 0x01, 0x01, 0x20 produce result 0x02.
- Third byte's `i_rx_done` coincident with the 4th tick (`TIMEOUT_TICKS`=4) -> no `o_timeout`; `o_tx_start` issued normally.
- Extra byte during `S_WAIT_TX` -> `o_overrun` 1-cycle pulse; no second `o_tx_start`; following command processed correctly.
- `i_rst` pulsed in `S_WAIT_OP` -> all outputs 0 immediately; no `o_tx_start`; a fresh 3-byte command then completes.
- Opcode byte 0xE0 with `NB_OP`=6 -> `o_alu_op`=6'h20.
